game_ctl: RTL and testbench
===========================

# game_ctl

Top-level game sequencer for Arkanoid. Runs the game state machine, gating the paddle, holding and launching the ball, counting lives and levels, and requesting brick-field reloads. It sits between the mouse front-end and the paddle, ball and brick blocks. Its outputs are all registered, so downstream blocks sample them directly on pclk.

## Interface
- LIVES_INIT, 3: lives loaded at game start (1..7)
- DELAY_FRAMES, 120: frames spent in LOST and CLEARED before advancing (1..255)
- LEVELS, 3: number of levels; clearing the last one wins (1..15)
- pclk  in  1  pixel clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse, once per frame
- mouse_left  in  1  left button level, synchronous to pclk
- ball_lost  in  1  one-cycle pulse from the ball block when the ball passes the paddle
- bricks_cleared  in  1  level signal from the brick block: no bricks remain
- state  out  3  IDLE=0, SERVE=1, PLAY=2, LOST=3, CLEARED=4, OVER=5
- lives  out  3  remaining lives
- level  out  4  current level, 0-based
- paddle_en  out  1  paddle follows the mouse when high
- ball_hold  out  1  ball is pinned to the paddle when high
- ball_launch  out  1  one-cycle pulse that releases the ball
- level_load  out  1  one-cycle pulse that makes the brick block load `level`
- game_over  out  1  high in OVER
- win  out  1  high in OVER when all levels were cleared

## Operation
- Click: `click = mouse_left & ~ml_q`, where ml_q is mouse_left registered. Only rising edges count. Holding the button does nothing further.
- Timer: 8-bit `tmr`.
  - Loaded with DELAY_FRAMES-1 on entry to LOST or CLEARED.
  - Decrements on frame_tick.
  - The state exits on the frame_tick that arrives while tmr==0, giving exactly DELAY_FRAMES ticks of dwell.
- IDLE: paddle_en=0, ball_hold=1. On click:
  - lives<=LIVES_INIT, level<=0, win<=0.
  - Pulse level_load.
  - Go to SERVE.
- SERVE: paddle_en=1, ball_hold=1. On click, pulse ball_launch and go to PLAY.
- PLAY: paddle_en=1, ball_hold=0.
  - bricks_cleared high → CLEARED. This takes priority when ball_lost arrives in the same cycle, and no life is lost in that case.
  - Otherwise, ball_lost with lives>1 → lives-1, go to LOST.
  - Otherwise, ball_lost with lives==1 → lives<=0, win<=0, go to OVER.
- LOST: paddle_en=0, ball_hold=1. On timer expiry → SERVE.
- CLEARED: paddle_en=0, ball_hold=1. On timer expiry:
  - If level==LEVELS-1: win<=1, go to OVER. Level is unchanged.
  - Else: level+1, pulse level_load in the same cycle the new level appears, go to SERVE.
- OVER: game_over=1, paddle_en=0, ball_hold=1. On click → IDLE. lives, level and win hold until the next game start.
- Inputs that are irrelevant to the current state are ignored. Examples: ball_lost outside PLAY, click in PLAY, LOST or CLEARED.
- Illegal state encodings (6, 7) → IDLE on the next edge.

## Timing
- Reset (reset low, asynchronous):
  - state=IDLE, lives=0, level=0, tmr=0, ml_q=0.
  - paddle_en=0, ball_hold=1, ball_launch=0, level_load=0, game_over=0, win=0.
  - Reset asserted mid-game aborts immediately. No pulse is emitted on release.
- Latency is one cycle. An event sampled at edge n is reflected in state and the outputs after edge n.
- ball_launch and level_load are each high for exactly one cycle. That cycle coincides with the first cycle of the new state (PLAY, or SERVE respectively).
- paddle_en, ball_hold and game_over are registered decodes of the next state. They never lag `state`.
- lives never wraps below 0. level never exceeds LEVELS-1.
- frame_tick together with click in the same cycle: each is handled only in the state that uses it. There is no interaction.

## Test plan
- Reset, then hold mouse_left=1 for 10 cycles starting after a 0 → only one transition IDLE→SERVE; level_load pulses once; lives=3, level=0.
- SERVE, click → state=PLAY on the next cycle, with one ball_launch pulse; ball_hold drops to 0 in the same cycle.
- PLAY with lives=3, ball_lost pulse → lives=2, state=LOST; with DELAY_FRAMES=4, returns to SERVE on the 4th frame_tick, not earlier.
- PLAY, ball_lost and bricks_cleared asserted in the same cycle → CLEARED, lives unchanged; after the delay, level=1, level_load pulse, SERVE.
- lives=1, ball_lost → OVER, lives=0, game_over=1, win=0. With LEVELS=1 instead, clearing the level → OVER with win=1. Click in OVER → IDLE.
- Drop reset while in PLAY with lives=2, level=1 → all outputs immediately take their reset values, with no dependence on pclk.

Source files
------------

// File: rtl/game_ctl.sv
// game_ctl: Arkanoid game sequencer.
// Runs the IDLE/SERVE/PLAY/LOST/CLEARED/OVER flow, counts lives and levels,
// gates the paddle, holds/launches the ball and requests brick-field reloads.
// Every output is registered so downstream blocks can sample it directly.
module game_ctl #(
  parameter int LIVES_INIT   = 3,   // 1..7
  parameter int DELAY_FRAMES = 120, // 1..255
  parameter int LEVELS       = 3    // 1..15
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       mouse_left,
  input  logic       ball_lost,
  input  logic       bricks_cleared,
  output logic [2:0] state,
  output logic [2:0] lives,
  output logic [3:0] level,
  output logic       paddle_en,
  output logic       ball_hold,
  output logic       ball_launch,
  output logic       level_load,
  output logic       game_over,
  output logic       win
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE   = 3'd1,
    PLAY    = 3'd2,
    LOST    = 3'd3,
    CLEARED = 3'd4,
    OVER    = 3'd5
  } state_t;

  localparam logic [7:0] TMR_LOAD   = 8'(DELAY_FRAMES - 1);
  localparam logic [3:0] LAST_LEVEL = 4'(LEVELS - 1);
  localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);

  state_t     state_q;
  state_t     state_d;
  logic       ml_q;
  logic       click;
  logic [7:0] tmr;
  logic [7:0] tmr_d;
  logic [2:0] lives_d;
  logic [3:0] level_d;
  logic       win_d;
  logic       launch_d;
  logic       load_d;
  logic       paddle_en_d;
  logic       ball_hold_d;
  logic       game_over_d;

  // Only the rising edge of the button counts as a click.
  assign click = mouse_left & ~ml_q;
  assign state = state_q;

  // State and all registered outputs; reset aborts the game instantly.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ml_q        <= 1'b0;
      tmr         <= '0;
      lives       <= '0;
      level       <= '0;
      win         <= 1'b0;
      ball_launch <= 1'b0;
      level_load  <= 1'b0;
      paddle_en   <= 1'b0;
      ball_hold   <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ml_q        <= mouse_left;
      tmr         <= tmr_d;
      lives       <= lives_d;
      level       <= level_d;
      win         <= win_d;
      ball_launch <= launch_d;
      level_load  <= load_d;
      paddle_en   <= paddle_en_d;
      ball_hold   <= ball_hold_d;
      game_over   <= game_over_d;
    end
  end

  // Next state, counters and one-cycle pulse requests.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr;
    lives_d  = lives;
    level_d  = level;
    win_d    = win;
    launch_d = 1'b0;
    load_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (click) begin
          lives_d = LIVES_LOAD;
          level_d = '0;
          win_d   = 1'b0;
          load_d  = 1'b1;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (click) begin
          launch_d = 1'b1;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        // A cleared field wins over a simultaneous ball loss.
        if (bricks_cleared) begin
          tmr_d   = TMR_LOAD;
          state_d = CLEARED;
        end else if (ball_lost) begin
          if (lives > 3'd1) begin
            lives_d = lives - 3'd1;
            tmr_d   = TMR_LOAD;
            state_d = LOST;
          end else begin
            lives_d = '0;
            win_d   = 1'b0;
            state_d = OVER;
          end
        end
      end
      LOST: begin
        if (frame_tick) begin
          if (tmr == '0) state_d = SERVE;
          else           tmr_d   = tmr - 8'd1;
        end
      end
      CLEARED: begin
        if (frame_tick) begin
          if (tmr == '0) begin
            if (level == LAST_LEVEL) begin
              win_d   = 1'b1;
              state_d = OVER;
            end else begin
              level_d = level + 4'd1;
              load_d  = 1'b1;
              state_d = SERVE;
            end
          end else begin
            tmr_d = tmr - 8'd1;
          end
        end
      end
      OVER: begin
        if (click) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Level outputs decoded from the next state so they never lag state.
  always_comb begin
    paddle_en_d = (state_d == SERVE) || (state_d == PLAY);
    ball_hold_d = (state_d != PLAY);
    game_over_d = (state_d == OVER);
  end

endmodule

// File: tb/tb_game_ctl.sv
// tb_game_ctl: directed scenarios plus randomized run against a reference model.
module tb_game_ctl;

  localparam int LIVES_INIT   = 3;
  localparam int DELAY_FRAMES = 4;
  localparam int LEVELS       = 2;

  logic       pclk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       mouse_left = 1'b0;
  logic       ball_lost = 1'b0;
  logic       bricks_cleared = 1'b0;
  logic [2:0] state;
  logic [2:0] lives;
  logic [3:0] level;
  logic       paddle_en, ball_hold, ball_launch, level_load, game_over, win;

  int total = 0;
  int bad   = 0;

  // Reference model: game mode, counts, and ticks seen since entering a delay state.
  int m_mode, m_lives, m_level, m_win, m_ticks, m_prev_ml, m_launch, m_load;

  game_ctl #(
    .LIVES_INIT  (LIVES_INIT),
    .DELAY_FRAMES(DELAY_FRAMES),
    .LEVELS      (LEVELS)
  ) dut (
    .pclk          (pclk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .mouse_left    (mouse_left),
    .ball_lost     (ball_lost),
    .bricks_cleared(bricks_cleared),
    .state         (state),
    .lives         (lives),
    .level         (level),
    .paddle_en     (paddle_en),
    .ball_hold     (ball_hold),
    .ball_launch   (ball_launch),
    .level_load    (level_load),
    .game_over     (game_over),
    .win           (win)
  );

  always #5 pclk = ~pclk;

  task automatic model_reset();
    m_mode = 0; m_lives = 0; m_level = 0; m_win = 0;
    m_ticks = 0; m_prev_ml = 0; m_launch = 0; m_load = 0;
  endtask

  task automatic model_update(input int ml, input int ft, input int bl, input int bc);
    int clk_ev;
    clk_ev = (ml == 1 && m_prev_ml == 0) ? 1 : 0;
    m_prev_ml = ml;
    m_launch = 0;
    m_load = 0;
    case (m_mode)
      0: if (clk_ev == 1) begin
           m_lives = LIVES_INIT; m_level = 0; m_win = 0; m_load = 1; m_mode = 1;
         end
      1: if (clk_ev == 1) begin m_launch = 1; m_mode = 2; end
      2: if (bc == 1) begin m_mode = 4; m_ticks = 0; end
         else if (bl == 1) begin
           if (m_lives > 1) begin m_lives--; m_mode = 3; m_ticks = 0; end
           else begin m_lives = 0; m_win = 0; m_mode = 5; end
         end
      3: if (ft == 1) begin
           m_ticks++;
           if (m_ticks == DELAY_FRAMES) m_mode = 1;
         end
      4: if (ft == 1) begin
           m_ticks++;
           if (m_ticks == DELAY_FRAMES) begin
             if (m_level == LEVELS - 1) begin m_win = 1; m_mode = 5; end
             else begin m_level++; m_load = 1; m_mode = 1; end
           end
         end
      5: if (clk_ev == 1) m_mode = 0;
      default: m_mode = 0;
    endcase
  endtask

  // One clock: drive on the falling edge, advance model at the rising edge, settle 1ns.
  task automatic step(input logic ml, input logic ft, input logic bl, input logic bc);
    @(negedge pclk);
    mouse_left = ml; frame_tick = ft; ball_lost = bl; bricks_cleared = bc;
    @(posedge pclk);
    model_update(int'(ml), int'(ft), int'(bl), int'(bc));
    #1;
  endtask

  task automatic click_once();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    total++;
    if ({state, lives, level} !== {3'd0, 3'd0, 4'd0}) begin
      bad++;
      $display("FAIL reset_counts: got st=%0d lives=%0d level=%0d want 0/0/0", state, lives, level);
    end
    total++;
    if ({paddle_en, ball_hold, ball_launch, level_load, game_over, win} !== 6'b010000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 010000",
               {paddle_en, ball_hold, ball_launch, level_load, game_over, win});
    end
    @(negedge pclk);
    reset = 1'b1;
  endtask

  task automatic test_start_hold();
    int loads, moves;
    logic [2:0] prev;
    loads = 0; moves = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    prev = state;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (level_load === 1'b1) loads++;
      if (state !== prev) moves++;
      prev = state;
    end
    total++;
    if (moves !== 1 || state !== 3'd1) begin
      bad++;
      $display("FAIL start_hold_state: got moves=%0d st=%0d want 1/1", moves, state);
    end
    total++;
    if (loads !== 1) begin
      bad++;
      $display("FAIL start_hold_load: got %0d pulses want 1", loads);
    end
    total++;
    if (lives !== 3'd3 || level !== 4'd0 || paddle_en !== 1'b1) begin
      bad++;
      $display("FAIL start_hold_counts: got lives=%0d level=%0d pen=%b want 3/0/1", lives, level, paddle_en);
    end
  endtask

  task automatic test_serve_launch();
    click_once();
    total++;
    if (state !== 3'd2 || ball_launch !== 1'b1 || ball_hold !== 1'b0) begin
      bad++;
      $display("FAIL serve_launch: got st=%0d launch=%b hold=%b want 2/1/0", state, ball_launch, ball_hold);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (ball_launch !== 1'b0 || state !== 3'd2) begin
      bad++;
      $display("FAIL launch_single: got launch=%b st=%0d want 0/2", ball_launch, state);
    end
  endtask

  task automatic test_lost_delay();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (state !== 3'd3 || lives !== 3'd2 || paddle_en !== 1'b0) begin
      bad++;
      $display("FAIL lost_entry: got st=%0d lives=%0d pen=%b want 3/2/0", state, lives, paddle_en);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (state !== 3'd3) begin
        bad++;
        $display("FAIL lost_early_exit: tick %0d got st=%0d want 3", i + 1, state);
      end
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (state !== 3'd1 || ball_hold !== 1'b1 || paddle_en !== 1'b1) begin
      bad++;
      $display("FAIL lost_exit: got st=%0d hold=%b pen=%b want 1/1/1", state, ball_hold, paddle_en);
    end
  endtask

  task automatic test_priority();
    click_once();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (state !== 3'd4 || lives !== 3'd2) begin
      bad++;
      $display("FAIL clear_priority: got st=%0d lives=%0d want 4/2", state, lives);
    end
    ticks(3);
    total++;
    if (state !== 3'd4) begin
      bad++;
      $display("FAIL clear_early_exit: got st=%0d want 4", state);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (state !== 3'd1 || level !== 4'd1 || level_load !== 1'b1) begin
      bad++;
      $display("FAIL next_level: got st=%0d level=%0d load=%b want 1/1/1", state, level, level_load);
    end
  endtask

  task automatic test_game_over();
    click_once();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(DELAY_FRAMES);
    click_once();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (state !== 3'd5 || lives !== 3'd0 || game_over !== 1'b1 || win !== 1'b0) begin
      bad++;
      $display("FAIL game_over: got st=%0d lives=%0d go=%b win=%b want 5/0/1/0", state, lives, game_over, win);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (lives !== 3'd0 || state !== 3'd5) begin
      bad++;
      $display("FAIL over_ignore_lost: got lives=%0d st=%0d want 0/5", lives, state);
    end
    click_once();
    total++;
    if (state !== 3'd0 || game_over !== 1'b0 || level !== 4'd1) begin
      bad++;
      $display("FAIL over_to_idle: got st=%0d go=%b level=%0d want 0/0/1", state, game_over, level);
    end
  endtask

  task automatic test_win();
    click_once();
    click_once();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(DELAY_FRAMES);
    click_once();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(DELAY_FRAMES);
    total++;
    if (state !== 3'd5 || win !== 1'b1 || level !== 4'd1 || level_load !== 1'b0 || lives !== 3'd3) begin
      bad++;
      $display("FAIL win: got st=%0d win=%b level=%0d load=%b lives=%0d want 5/1/1/0/3",
               state, win, level, level_load, lives);
    end
    click_once();
    total++;
    if (state !== 3'd0 || win !== 1'b1 || level !== 4'd1 || lives !== 3'd3) begin
      bad++;
      $display("FAIL idle_hold: got st=%0d win=%b level=%0d lives=%0d want 0/1/1/3", state, win, level, lives);
    end
  endtask

  task automatic test_async_reset();
    click_once();
    click_once();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(DELAY_FRAMES);
    click_once();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(DELAY_FRAMES);
    click_once();
    total++;
    if (state !== 3'd2 || lives !== 3'd2 || level !== 4'd1) begin
      bad++;
      $display("FAIL async_setup: got st=%0d lives=%0d level=%0d want 2/2/1", state, lives, level);
    end
    @(negedge pclk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({state, lives, level} !== 10'd0 ||
        {paddle_en, ball_hold, ball_launch, level_load, game_over, win} !== 6'b010000) begin
      bad++;
      $display("FAIL async_reset: got st=%0d lives=%0d level=%0d flags=%b want 0/0/0/010000",
               state, lives, level, {paddle_en, ball_hold, ball_launch, level_load, game_over, win});
    end
    model_reset();
    @(negedge pclk);
    mouse_left = 1'b0; frame_tick = 1'b0; ball_lost = 1'b0; bricks_cleared = 1'b0;
    @(negedge pclk);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (ball_launch !== 1'b0 || level_load !== 1'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL release_quiet: got launch=%b load=%b st=%0d want 0/0/0", ball_launch, level_load, state);
    end
  endtask

  task automatic test_random();
    logic ml, ft, bl, bc;
    ml = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 2) == 0) ml = ~ml;
      ft = ($urandom_range(0, 2) == 0);
      bl = ($urandom_range(0, 9) == 0);
      bc = ($urandom_range(0, 24) == 0);
      step(ml, ft, bl, bc);
      total++;
      if (state !== 3'(m_mode) || lives !== 3'(m_lives) || level !== 4'(m_level) || win !== 1'(m_win)) begin
        bad++;
        $display("FAIL rand_state: cycle %0d got st=%0d lives=%0d level=%0d win=%b want %0d/%0d/%0d/%0d",
                 n, state, lives, level, win, m_mode, m_lives, m_level, m_win);
      end
      total++;
      if (ball_launch !== 1'(m_launch) || level_load !== 1'(m_load) ||
          paddle_en !== (m_mode == 1 || m_mode == 2) || ball_hold !== (m_mode != 2) ||
          game_over !== (m_mode == 5)) begin
        bad++;
        $display("FAIL rand_flags: cycle %0d got launch=%b load=%b pen=%b hold=%b go=%b mode=%0d",
                 n, ball_launch, level_load, paddle_en, ball_hold, game_over, m_mode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_serve_launch();
    test_lost_delay();
    test_priority();
    test_game_over();
    test_win();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
